acc_multi_dispatcher: RTL and testbench

// Dispatches non-speculative accelerator instructions from the issue stage to NrAcc accelerator channels.

---
 rtl/acc_multi_dispatcher.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_acc_multi_dispatcher.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_multi_dispatcher.sv
// acc_multi_dispatcher
// Dispatches non-speculative accelerator instructions from the issue stage
// into NrAcc per-channel instruction queues. A queue head is only offered to
// its accelerator once its scoreboard id has reached the commit point. The
// commit-cycle bypass lets a head go out in the same cycle as its commit.
// Per-channel load/store counters drive the scalar memory-consistency stall.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   issue_*                        issue-stage offer (valid/ready handshake)
//   scalar_ld_i/st_i, cons_en_i    scalar memory-op presence, consistency mode
//   scalar_stall_o                 stall the scalar load/store
//   commit_valid_i/trans_id_i      head-of-scoreboard accel instruction
//   flush_i                        drop all speculative state
//   acc_req_*                      per-channel request (fall-through from queue head)
//   acc_ld_done_i/st_done_i        per-channel completion of one dispatched ld/st
//   cnt_ovf_o                      sticky counter over/underflow flag
//   perf_disp_o                    per-channel accepted-request count
//
// Optional feature macro: ACC_DISP_PERF_CNT_EN enables the perf_disp_o
// counters. When it is undefined, perf_disp_o is tied to zero.

// Per-channel instruction FIFO. Head is presented combinationally.
module acc_disp_chan #(
  parameter int unsigned Depth = 4,
  parameter type         entry_t = logic,
  localparam int unsigned UseW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  entry_t          entry_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic            empty_o,
  output logic [UseW-1:0] usage_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [UseW-1:0] usage_q, usage_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    do_pop   = pop_i & (usage_q != '0);
    // A full queue may only take a new entry when it also drains one.
    do_push  = push_i & ((usage_q != UseW'(Depth)) | do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = entry_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      usage_d = usage_q + UseW'(1);
      else if (do_pop && !do_push) usage_d = usage_q - UseW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
endmodule

module acc_multi_dispatcher #(
  parameter int unsigned NrAcc       = 2,
  parameter int unsigned QueueDepth  = 4,
  parameter int unsigned NrSbEntries = 8,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned CntWidth    = 3,
  localparam int unsigned TransIdBits = (NrSbEntries > 1) ? $clog2(NrSbEntries) : 1,
  localparam int unsigned SelW        = (NrAcc > 1) ? $clog2(NrAcc) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 issue_valid_i,
  input  logic [SelW-1:0]                      issue_acc_sel_i,
  input  logic [31:0]                          issue_insn_i,
  input  logic [XLEN-1:0]                      issue_rs1_i,
  input  logic [XLEN-1:0]                      issue_rs2_i,
  input  logic [TransIdBits-1:0]               issue_trans_id_i,
  input  logic                                 issue_is_ld_i,
  input  logic                                 issue_is_st_i,
  output logic                                 issue_ready_o,
  input  logic                                 scalar_ld_i,
  input  logic                                 scalar_st_i,
  input  logic                                 cons_en_i,
  output logic                                 scalar_stall_o,
  input  logic                                 commit_valid_i,
  input  logic [TransIdBits-1:0]               commit_trans_id_i,
  input  logic                                 flush_i,
  output logic [NrAcc-1:0]                     acc_req_valid_o,
  input  logic [NrAcc-1:0]                     acc_req_ready_i,
  output logic [NrAcc-1:0][31:0]               acc_req_insn_o,
  output logic [NrAcc-1:0][XLEN-1:0]           acc_req_rs1_o,
  output logic [NrAcc-1:0][XLEN-1:0]           acc_req_rs2_o,
  output logic [NrAcc-1:0][TransIdBits-1:0]    acc_req_tid_o,
  input  logic [NrAcc-1:0]                     acc_ld_done_i,
  input  logic [NrAcc-1:0]                     acc_st_done_i,
  output logic                                 cnt_ovf_o,
  output logic [NrAcc-1:0][31:0]               perf_disp_o
);
  localparam int unsigned UseW = $clog2(QueueDepth + 1);

  typedef struct packed {
    logic [31:0]            insn;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [TransIdBits-1:0] tid;
    logic                   ld;
    logic                   st;
  } entry_t;

  entry_t                      issue_entry;
  entry_t                      head [NrAcc];
  logic [NrAcc-1:0]            push, pop, empty, head_rdy;
  logic [NrAcc-1:0][UseW-1:0]  usage;
  logic                        push_ok, commit_hit;

  logic [NrSbEntries-1:0]      pending_q, pending_d, ready_q, ready_d;
  logic [NrAcc-1:0][CntWidth-1:0] spec_ld_q, spec_ld_d, spec_st_q, spec_st_d;
  logic [NrAcc-1:0][CntWidth-1:0] disp_ld_q, disp_ld_d, disp_st_q, disp_st_d;
  logic                        ovf_q, ovf_d;
  logic                        any_ld_pend, any_st_pend;

  assign issue_entry = '{insn: issue_insn_i, rs1: issue_rs1_i, rs2: issue_rs2_i,
                         tid: issue_trans_id_i, ld: issue_is_ld_i, st: issue_is_st_i};

  always_comb begin
    issue_ready_o = 1'b0;
    if (32'(issue_acc_sel_i) < NrAcc)
      issue_ready_o = (usage[issue_acc_sel_i] < UseW'(QueueDepth));
  end

  // A handshake that coincides with a flush is discarded.
  assign push_ok    = issue_valid_i & issue_ready_o & ~flush_i;
  assign commit_hit = commit_valid_i & pending_q[commit_trans_id_i];

  for (genvar c = 0; c < NrAcc; c++) begin : g_chan
    assign push[c] = push_ok & (issue_acc_sel_i == SelW'(c));

    acc_disp_chan #(
      .Depth   (QueueDepth),
      .entry_t (entry_t)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push[c]),
      .entry_i (issue_entry),
      .pop_i   (pop[c]),
      .head_o  (head[c]),
      .empty_o (empty[c]),
      .usage_o (usage[c])
    );

    assign head_rdy[c] = ~empty[c] & ready_q[head[c].tid];
    // Commit bypass: the head may go out in the very cycle its id commits.
    assign acc_req_valid_o[c] = head_rdy[c] |
      (~empty[c] & commit_hit & (commit_trans_id_i == head[c].tid));
    assign pop[c]            = acc_req_valid_o[c] & acc_req_ready_i[c];
    assign acc_req_insn_o[c] = head[c].insn;
    assign acc_req_rs1_o[c]  = head[c].rs1;
    assign acc_req_rs2_o[c]  = head[c].rs2;
    assign acc_req_tid_o[c]  = head[c].tid;
  end

  // Commit marks the id ready; a pop in the same cycle clears it again so a
  // bypassed dispatch leaves no stale ready bit behind.
  always_comb begin
    pending_d = pending_q;
    ready_d   = ready_q;
    if (flush_i) begin
      pending_d = '0;
      ready_d   = '0;
    end else begin
      if (commit_hit) begin
        pending_d[commit_trans_id_i] = 1'b0;
        ready_d[commit_trans_id_i]   = 1'b1;
      end
      for (int c = 0; c < NrAcc; c++)
        if (pop[c]) ready_d[head[c].tid] = 1'b0;
      if (push_ok) pending_d[issue_trans_id_i] = 1'b1;
    end
  end

  // Saturating step; MSB of the result flags an attempted over/underflow.
  function automatic logic [CntWidth:0] sat_step(input logic [CntWidth-1:0] v,
                                                 input logic inc, input logic dec);
    logic [CntWidth:0] r;
    r = {1'b0, v};
    if (inc && !dec) begin
      if (v == '1) r[CntWidth] = 1'b1;
      else         r[CntWidth-1:0] = v + CntWidth'(1);
    end else if (dec && !inc) begin
      if (v == '0) r[CntWidth] = 1'b1;
      else         r[CntWidth-1:0] = v - CntWidth'(1);
    end
    return r;
  endfunction

  always_comb begin
    logic [CntWidth:0] s;
    s           = '0;
    ovf_d       = ovf_q;
    spec_ld_d   = spec_ld_q;
    spec_st_d   = spec_st_q;
    disp_ld_d   = disp_ld_q;
    disp_st_d   = disp_st_q;
    any_ld_pend = 1'b0;
    any_st_pend = 1'b0;
    for (int c = 0; c < NrAcc; c++) begin
      s = sat_step(spec_ld_q[c], push[c] & issue_is_ld_i, pop[c] & head[c].ld);
      spec_ld_d[c] = s[CntWidth-1:0];
      ovf_d        = ovf_d | s[CntWidth];
      s = sat_step(spec_st_q[c], push[c] & issue_is_st_i, pop[c] & head[c].st);
      spec_st_d[c] = s[CntWidth-1:0];
      ovf_d        = ovf_d | s[CntWidth];
      s = sat_step(disp_ld_q[c], pop[c] & head[c].ld, acc_ld_done_i[c]);
      disp_ld_d[c] = s[CntWidth-1:0];
      ovf_d        = ovf_d | s[CntWidth];
      s = sat_step(disp_st_q[c], pop[c] & head[c].st, acc_st_done_i[c]);
      disp_st_d[c] = s[CntWidth-1:0];
      ovf_d        = ovf_d | s[CntWidth];
      // Dispatched ops are already outside the speculation window.
      if (flush_i) begin
        spec_ld_d[c] = '0;
        spec_st_d[c] = '0;
      end
      any_ld_pend = any_ld_pend | (spec_ld_q[c] != '0) | (disp_ld_q[c] != '0);
      any_st_pend = any_st_pend | (spec_st_q[c] != '0) | (disp_st_q[c] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      ready_q   <= '0;
      spec_ld_q <= '0;
      spec_st_q <= '0;
      disp_ld_q <= '0;
      disp_st_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ready_q   <= ready_d;
      spec_ld_q <= spec_ld_d;
      spec_st_q <= spec_st_d;
      disp_ld_q <= disp_ld_d;
      disp_st_q <= disp_st_d;
      ovf_q     <= ovf_d;
    end
  end

  assign cnt_ovf_o      = ovf_q;
  assign scalar_stall_o = cons_en_i & ((scalar_ld_i & any_st_pend) |
                                       (scalar_st_i & (any_st_pend | any_ld_pend)));

`ifdef ACC_DISP_PERF_CNT_EN
  logic [NrAcc-1:0][31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int c = 0; c < NrAcc; c++)
      if (pop[c]) perf_d[c] = perf_q[c] + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_disp_o = perf_q;
`else
  assign perf_disp_o = '0;
`endif

  // Flushing while a committed head still waits for its accelerator would
  // silently lose a non-speculative instruction.
  flush_ready_head_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(flush_i && (|head_rdy)));

endmodule

// File: tb/tb_acc_multi_dispatcher.sv
// Self-checking bench for acc_multi_dispatcher (NrAcc=2, QueueDepth=4,
// NrSbEntries=8, XLEN=64, CntWidth=3). Issued entries are pushed to a
// per-channel expected queue; a monitor pops and compares on each accepted
// request. Scenario tasks add their own inline checks.
module tb_acc_multi_dispatcher;
  localparam int NR = 2;
  localparam int XL = 64;
  localparam int TW = 3;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   issue_valid_i;
  logic [0:0]             issue_acc_sel_i;
  logic [31:0]            issue_insn_i;
  logic [XL-1:0]          issue_rs1_i, issue_rs2_i;
  logic [TW-1:0]          issue_trans_id_i;
  logic                   issue_is_ld_i, issue_is_st_i, issue_ready_o;
  logic                   scalar_ld_i, scalar_st_i, cons_en_i, scalar_stall_o;
  logic                   commit_valid_i;
  logic [TW-1:0]          commit_trans_id_i;
  logic                   flush_i;
  logic [NR-1:0]          acc_req_valid_o, acc_req_ready_i;
  logic [NR-1:0][31:0]    acc_req_insn_o;
  logic [NR-1:0][XL-1:0]  acc_req_rs1_o, acc_req_rs2_o;
  logic [NR-1:0][TW-1:0]  acc_req_tid_o;
  logic [NR-1:0]          acc_ld_done_i, acc_st_done_i;
  logic                   cnt_ovf_o;
  logic [NR-1:0][31:0]    perf_disp_o;

  always #5 clk_i = ~clk_i;

  acc_multi_dispatcher #(
    .NrAcc(NR), .QueueDepth(4), .NrSbEntries(8), .XLEN(XL), .CntWidth(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_acc_sel_i(issue_acc_sel_i),
    .issue_insn_i(issue_insn_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_trans_id_i(issue_trans_id_i), .issue_is_ld_i(issue_is_ld_i),
    .issue_is_st_i(issue_is_st_i), .issue_ready_o(issue_ready_o),
    .scalar_ld_i(scalar_ld_i), .scalar_st_i(scalar_st_i), .cons_en_i(cons_en_i),
    .scalar_stall_o(scalar_stall_o),
    .commit_valid_i(commit_valid_i), .commit_trans_id_i(commit_trans_id_i),
    .flush_i(flush_i),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_insn_o(acc_req_insn_o), .acc_req_rs1_o(acc_req_rs1_o),
    .acc_req_rs2_o(acc_req_rs2_o), .acc_req_tid_o(acc_req_tid_o),
    .acc_ld_done_i(acc_ld_done_i), .acc_st_done_i(acc_st_done_i),
    .cnt_ovf_o(cnt_ovf_o), .perf_disp_o(perf_disp_o)
  );

  typedef struct {
    logic [31:0]   insn;
    logic [XL-1:0] rs1;
    logic [XL-1:0] rs2;
    logic [TW-1:0] tid;
  } exp_t;

  exp_t exp_q [NR][$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   accepted [NR];

  // Scoreboard monitor: sampled mid-cycle, a valid&ready pair is an accept at
  // the coming rising edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int c = 0; c < NR; c++) begin
        if (acc_req_valid_o[c] && acc_req_ready_i[c]) begin
          checks++;
          accepted[c]++;
          if (exp_q[c].size() == 0) begin
            errors++;
            $display("FAIL unexpected_req ch%0d got tid=%0d, expected no request", c, acc_req_tid_o[c]);
          end else begin
            mon_e = exp_q[c].pop_front();
            if (acc_req_insn_o[c] !== mon_e.insn || acc_req_rs1_o[c] !== mon_e.rs1 ||
                acc_req_rs2_o[c] !== mon_e.rs2 || acc_req_tid_o[c] !== mon_e.tid) begin
              errors++;
              $display("FAIL req_fields ch%0d got tid=%0d insn=%h rs1=%h, expected tid=%0d insn=%h rs1=%h",
                       c, acc_req_tid_o[c], acc_req_insn_o[c], acc_req_rs1_o[c],
                       mon_e.tid, mon_e.insn, mon_e.rs1);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic drive_idle();
    issue_valid_i = 0; issue_acc_sel_i = 0; issue_insn_i = 0; issue_rs1_i = 0; issue_rs2_i = 0;
    issue_trans_id_i = 0; issue_is_ld_i = 0; issue_is_st_i = 0;
    scalar_ld_i = 0; scalar_st_i = 0; cons_en_i = 0;
    commit_valid_i = 0; commit_trans_id_i = 0; flush_i = 0;
    acc_req_ready_i = 0; acc_ld_done_i = 0; acc_st_done_i = 0;
  endtask

  // One issue handshake; the caller guarantees the target queue has room.
  task automatic do_issue(input int ch, input logic [TW-1:0] tid, input logic ld, input logic st);
    exp_t e;
    issue_valid_i = 1; issue_acc_sel_i = ch[0]; issue_trans_id_i = tid;
    issue_is_ld_i = ld; issue_is_st_i = st;
    issue_insn_i = $urandom; issue_rs1_i = {$urandom, $urandom}; issue_rs2_i = {$urandom, $urandom};
    e.insn = issue_insn_i; e.rs1 = issue_rs1_i; e.rs2 = issue_rs2_i; e.tid = tid;
    exp_q[ch].push_back(e);
    tick();
    issue_valid_i = 0; issue_is_ld_i = 0; issue_is_st_i = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_ni = 0;
    repeat (3) tick();
    checks++; if (acc_req_valid_o !== '0) begin errors++; $display("FAIL reset_req_valid got %b, expected 00", acc_req_valid_o); end
    checks++; if (cnt_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b, expected 0", cnt_ovf_o); end
    checks++; if (perf_disp_o !== '0) begin errors++; $display("FAIL reset_perf got %h, expected 0", perf_disp_o); end
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b, expected 1", issue_ready_o); end
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b, expected 0", scalar_stall_o); end
    rst_ni = 1;
    tick();
  endtask

  task automatic test_commit_dispatch();
    do_issue(1, 3'd3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (acc_req_valid_o[1] !== 1'b0) begin errors++; $display("FAIL req_before_commit got %b, expected 0", acc_req_valid_o[1]); end
      tick();
    end
    commit_valid_i = 1; commit_trans_id_i = 3; acc_req_ready_i = 2'b10;
    #1;
    checks++; if (acc_req_valid_o[1] !== 1'b1) begin errors++; $display("FAIL req_in_commit_cycle got %b, expected 1", acc_req_valid_o[1]); end
    checks++; if (acc_req_tid_o[1] !== 3'd3) begin errors++; $display("FAIL req_tid got %0d, expected 3", acc_req_tid_o[1]); end
    tick();
    commit_valid_i = 0;
    #1;
    checks++; if (acc_req_valid_o !== '0) begin errors++; $display("FAIL req_after_pop got %b, expected 00", acc_req_valid_o); end
    acc_req_ready_i = 0;
    checks++; if (exp_q[1].size() != 0) begin errors++; $display("FAIL sb_drained_commit got %0d left, expected 0", exp_q[1].size()); end
  endtask

  task automatic test_backpressure();
    acc_req_ready_i = 0;
    for (int i = 0; i < 4; i++) do_issue(0, 3'(i), 0, 0);
    issue_acc_sel_i = 0; #1;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ch0_ready got %b, expected 0", issue_ready_o); end
    issue_acc_sel_i = 1; #1;
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL ch1_ready_while_ch0_full got %b, expected 1", issue_ready_o); end
    do_issue(1, 3'd4, 0, 0);
    checks++; if (acc_req_valid_o !== '0) begin errors++; $display("FAIL req_without_commit got %b, expected 00", acc_req_valid_o); end
    acc_req_ready_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      commit_valid_i = 1; commit_trans_id_i = 3'(i);
      tick();
    end
    commit_valid_i = 0; acc_req_ready_i = 0; issue_acc_sel_i = 0;
    #1;
    checks++; if (acc_req_valid_o !== '0) begin errors++; $display("FAIL req_after_drain got %b, expected 00", acc_req_valid_o); end
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL ch0_ready_after_drain got %b, expected 1", issue_ready_o); end
    checks++; if (exp_q[0].size() + exp_q[1].size() != 0) begin errors++; $display("FAIL sb_drained_bp got %0d left, expected 0", exp_q[0].size() + exp_q[1].size()); end
  endtask

  task automatic test_consistency();
    cons_en_i = 1; scalar_ld_i = 1; #1;
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL stall_idle got %b, expected 0", scalar_stall_o); end
    do_issue(0, 3'd5, 0, 1);
    checks++; if (scalar_stall_o !== 1'b1) begin errors++; $display("FAIL stall_ld_vs_spec_st got %b, expected 1", scalar_stall_o); end
    cons_en_i = 0; #1;
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL stall_cons_off got %b, expected 0", scalar_stall_o); end
    cons_en_i = 1;
    acc_req_ready_i = 2'b01; commit_valid_i = 1; commit_trans_id_i = 5;
    tick();
    commit_valid_i = 0; acc_req_ready_i = 0; #1;
    checks++; if (scalar_stall_o !== 1'b1) begin errors++; $display("FAIL stall_ld_vs_disp_st got %b, expected 1", scalar_stall_o); end
    acc_st_done_i = 2'b01;
    tick();
    acc_st_done_i = 0; #1;
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL stall_after_st_done got %b, expected 0", scalar_stall_o); end
    do_issue(1, 3'd6, 1, 0);
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL no_stall_ld_vs_ld got %b, expected 0", scalar_stall_o); end
    scalar_ld_i = 0; scalar_st_i = 1; #1;
    checks++; if (scalar_stall_o !== 1'b1) begin errors++; $display("FAIL stall_st_vs_ld got %b, expected 1", scalar_stall_o); end
    acc_req_ready_i = 2'b10; commit_valid_i = 1; commit_trans_id_i = 6;
    tick();
    commit_valid_i = 0; acc_req_ready_i = 0; acc_ld_done_i = 2'b10;
    tick();
    acc_ld_done_i = 0; #1;
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL stall_after_ld_done got %b, expected 0", scalar_stall_o); end
    scalar_st_i = 0; cons_en_i = 0;
  endtask

  task automatic test_flush();
    acc_req_ready_i = 0;
    do_issue(0, 3'd0, 1, 0);
    do_issue(0, 3'd1, 1, 0);
    cons_en_i = 1; scalar_st_i = 1; #1;
    checks++; if (scalar_stall_o !== 1'b1) begin errors++; $display("FAIL stall_before_flush got %b, expected 1", scalar_stall_o); end
    // Flush cycle with a concurrent issue to ch1 that must be dropped.
    flush_i = 1;
    issue_valid_i = 1; issue_acc_sel_i = 1; issue_trans_id_i = 2; issue_is_ld_i = 1;
    tick();
    flush_i = 0; issue_valid_i = 0; issue_is_ld_i = 0;
    exp_q[0].delete();
    #1;
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL stall_after_flush got %b, expected 0", scalar_stall_o); end
    acc_req_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      commit_valid_i = 1; commit_trans_id_i = (i == 0) ? 3'd2 : 3'(i - 1);
      #1;
      checks++; if (acc_req_valid_o !== '0) begin errors++; $display("FAIL req_after_flush tid%0d got %b, expected 00", commit_trans_id_i, acc_req_valid_o); end
      tick();
    end
    commit_valid_i = 0;
    do_issue(0, 3'd7, 0, 0);
    commit_valid_i = 1; commit_trans_id_i = 7; #1;
    checks++; if (acc_req_valid_o[0] !== 1'b1 || acc_req_tid_o[0] !== 3'd7) begin
      errors++; $display("FAIL head_after_flush got v=%b tid=%0d, expected v=1 tid=7", acc_req_valid_o[0], acc_req_tid_o[0]);
    end
    tick();
    commit_valid_i = 0; acc_req_ready_i = 0; scalar_st_i = 0; cons_en_i = 0;
    checks++; if (exp_q[0].size() != 0) begin errors++; $display("FAIL sb_drained_flush got %0d left, expected 0", exp_q[0].size()); end
  endtask

  task automatic test_saturation();
    checks++; if (cnt_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear_before got %b, expected 0", cnt_ovf_o); end
    acc_req_ready_i = 2'b01;
    for (int i = 0; i < 8; i++) begin
      do_issue(0, 3'(i), 1, 0);
      commit_valid_i = 1; commit_trans_id_i = 3'(i);
      tick();
      commit_valid_i = 0;
    end
    acc_req_ready_i = 0;
    checks++; if (cnt_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b, expected 1", cnt_ovf_o); end
    cons_en_i = 1; scalar_st_i = 1;
    // Saturated at 7: six completions leave 1, the seventh empties it.
    for (int i = 0; i < 6; i++) begin
      acc_ld_done_i = 2'b01; tick();
    end
    acc_ld_done_i = 0; #1;
    checks++; if (scalar_stall_o !== 1'b1) begin errors++; $display("FAIL sat_after_6_done got stall=%b, expected 1", scalar_stall_o); end
    acc_ld_done_i = 2'b01; tick();
    acc_ld_done_i = 0; #1;
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL sat_after_7_done got stall=%b, expected 0", scalar_stall_o); end
    acc_ld_done_i = 2'b01; tick();
    acc_ld_done_i = 0;
    repeat (2) tick();
    checks++; if (scalar_stall_o !== 1'b0) begin errors++; $display("FAIL underflow_holds_zero got stall=%b, expected 0", scalar_stall_o); end
    checks++; if (cnt_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b, expected 1", cnt_ovf_o); end
    cons_en_i = 0; scalar_st_i = 0;
  endtask

  task automatic test_perf_back_to_back();
    int exp_perf;
    rst_ni = 0;
    drive_idle();
    repeat (2) tick();
    for (int c = 0; c < NR; c++) begin exp_q[c].delete(); accepted[c] = 0; end
    rst_ni = 1;
    tick();
    checks++; if (cnt_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_cleared_by_reset got %b, expected 0", cnt_ovf_o); end
    acc_req_ready_i = 2'b10;
    do_issue(1, 3'd0, 0, 0);
    // Each step pushes tid i while the committed tid i-1 pops from the same queue.
    for (int i = 1; i < 5; i++) begin
      commit_valid_i = 1; commit_trans_id_i = 3'(i - 1);
      do_issue(1, 3'(i), 0, 0);
    end
    commit_valid_i = 1; commit_trans_id_i = 4;
    tick();
    commit_valid_i = 0; acc_req_ready_i = 0; #1;
    checks++; if (accepted[1] != 5 || exp_q[1].size() != 0) begin
      errors++; $display("FAIL b2b_accepts got %0d accepted %0d left, expected 5 accepted 0 left", accepted[1], exp_q[1].size());
    end
    checks++; if (acc_req_valid_o !== '0) begin errors++; $display("FAIL req_after_b2b got %b, expected 00", acc_req_valid_o); end
`ifdef ACC_DISP_PERF_CNT_EN
    exp_perf = 5;
`else
    exp_perf = 0;
`endif
    checks++; if (perf_disp_o[1] !== 32'(exp_perf)) begin errors++; $display("FAIL perf_ch1 got %0d, expected %0d", perf_disp_o[1], exp_perf); end
    checks++; if (perf_disp_o[0] !== 32'd0) begin errors++; $display("FAIL perf_ch0 got %0d, expected 0", perf_disp_o[0]); end
  endtask

  initial begin
    for (int c = 0; c < NR; c++) accepted[c] = 0;
    test_reset();
    test_commit_dispatch();
    test_backpressure();
    test_consistency();
    test_flush();
    test_saturation();
    test_perf_back_to_back();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
